wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 16 +
 rtl/wb_arbiter_rr_arbiter.sv | 32 +++
 rtl/wb_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter: register-file geometry,
// the default data width and the hard-wired zero register index.
package wb_arbiter_pkg;

   localparam int NUM_REGS     = 32;
   localparam int REG_IDX_W    = $clog2(NUM_REGS);
   localparam int XLEN_DEFAULT = 64;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

   // x0 is architecturally constant and must never be written or forwarded.
   function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] idx);
      return idx == REG_ZERO;
   endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin grant selection: search starts at ptr_i, goes up in index and
// wraps to 0; the first asserted request wins. Output is one-hot or zero.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o
);

   logic found;

   // Two passes: indices at/above the pointer first, then the wrapped ones.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!found && req_i[j] && (j >= int'(ptr_i))) begin
            gnt_o[j] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!found && req_i[j] && (j < int'(ptr_i))) begin
            gnt_o[j] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: NREQ requesters compete for one register-file write
// port. Grants are round-robin and combinational; the winning write is
// registered and presented on rf_* one cycle later.
// Optional macro WB_FWD_EN adds a bypass of the in-flight write onto two
// register-file read operands.
//
// Handshake: a requester transfers when req_valid[i] and req_ready[i] are
// both high at a posedge. req_ready never depends on req_ready of others
// or on data; it is one-hot or zero, zero during reset or freeze, and
// only ever high for a requester whose req_valid is high.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       freeze,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*REG_IDX_W-1:0]  req_rd,
   input  logic [NREQ*XLEN-1:0]       req_wd,
   output logic                       rf_we,
   output logic [REG_IDX_W-1:0]       rf_rd,
   output logic [XLEN-1:0]            rf_wd,
   output logic                       busy
`ifdef WB_FWD_EN
   ,
   input  logic [REG_IDX_W-1:0]       fwd_rs1,
   input  logic [REG_IDX_W-1:0]       fwd_rs2,
   input  logic [XLEN-1:0]            rf_rd1,
   input  logic [XLEN-1:0]            rf_rd2,
   output logic [XLEN-1:0]            op_rd1,
   output logic [XLEN-1:0]            op_rd2
`endif
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic                 rf_we_q, rf_we_d;
   logic [REG_IDX_W-1:0] rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]      rf_wd_q, rf_wd_d;

   logic [NREQ-1:0]      req_masked;
   logic [NREQ-1:0]      gnt;
   logic                 xfer;
   logic [PTR_W-1:0]     gnt_idx;
   logic [REG_IDX_W-1:0] sel_rd;
   logic [XLEN-1:0]      sel_wd;

   // Nothing may be granted while in reset or frozen.
   assign req_masked = (rst || freeze) ? '0 : req_valid;

   rr_arbiter #(
      .N     (NREQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req_i (req_masked),
      .ptr_i (ptr_q),
      .gnt_o (gnt)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   // Mux the granted requester's index and data onto the write path.
   always_comb begin
      gnt_idx = '0;
      sel_rd  = '0;
      sel_wd  = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt[j]) begin
            gnt_idx = PTR_W'(j);
            sel_rd  = req_rd[j*REG_IDX_W +: REG_IDX_W];
            sel_wd  = req_wd[j*XLEN +: XLEN];
         end
      end
   end

   // Next-state: capture a granted write (x0 writes are consumed but
   // suppressed), advance the pointer past the winner, else hold.
   always_comb begin
      rf_we_d = 1'b0;
      rf_rd_d = rf_rd_q;
      rf_wd_d = rf_wd_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         rf_we_d = !is_zero_reg(sel_rd);
         rf_rd_d = sel_rd;
         rf_wd_d = sel_wd;
         ptr_d   = (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Output registers and priority pointer; reset cancels any pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q <= 1'b0;
         rf_rd_q <= '0;
         rf_wd_q <= '0;
         ptr_q   <= '0;
      end else begin
         rf_we_q <= rf_we_d;
         rf_rd_q <= rf_rd_d;
         rf_wd_q <= rf_wd_d;
         ptr_q   <= ptr_d;
      end
   end

   assign rf_we = rf_we_q;
   assign rf_rd = rf_rd_q;
   assign rf_wd = rf_wd_q;
   assign busy  = rf_we_q;

`ifdef WB_FWD_EN
   // Bypass the write being presented this cycle onto matching operands.
   always_comb begin
      op_rd1 = rf_rd1;
      op_rd2 = rf_rd2;
      if (rf_we_q && (rf_rd_q == fwd_rs1) && !is_zero_reg(fwd_rs1)) begin
         op_rd1 = rf_wd_q;
      end
      if (rf_we_q && (rf_rd_q == fwd_rs2) && !is_zero_reg(fwd_rs2)) begin
         op_rd2 = rf_wd_q;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (NREQ=3, XLEN=64): directed vector table, a
// scoreboarded stream with a reference round-robin model, and, when
// WB_FWD_EN is defined, the operand bypass.
module tb_wb_arbiter;

   localparam int NREQ = 3;
   localparam int XLEN = 64;
   localparam int SB_W = 1 + 5 + XLEN;

   localparam logic [63:0] D0 = 64'hDEAD_BEEF_0000_0001;
   localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D2 = 64'h5A5A_0000_C3C3_0002;
   localparam logic [63:0] DF = 64'hFFFF_FFFF_FFFF_FFFF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst = 1'b1;
   logic                 freeze = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*5-1:0]    req_rd = '0;
   logic [NREQ*XLEN-1:0] req_wd = '0;
   logic                 rf_we;
   logic [4:0]           rf_rd;
   logic [XLEN-1:0]      rf_wd;
   logic                 busy;
`ifdef WB_FWD_EN
   logic [4:0]           fwd_rs1 = '0;
   logic [4:0]           fwd_rs2 = '0;
   logic [XLEN-1:0]      rf_rd1 = '0;
   logic [XLEN-1:0]      rf_rd2 = '0;
   logic [XLEN-1:0]      op_rd1;
   logic [XLEN-1:0]      op_rd2;
`endif

   wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .freeze    (freeze),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rd    (req_rd),
      .req_wd    (req_wd),
      .rf_we     (rf_we),
      .rf_rd     (rf_rd),
      .rf_wd     (rf_wd),
      .busy      (busy)
`ifdef WB_FWD_EN
      ,
      .fwd_rs1   (fwd_rs1),
      .fwd_rs2   (fwd_rs2),
      .rf_rd1    (rf_rd1),
      .rf_rd2    (rf_rd2),
      .op_rd1    (op_rd1),
      .op_rd2    (op_rd2)
`endif
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [SB_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic             rst;
      logic             freeze;
      logic [2:0]       valid;
      logic [14:0]      rd;
      logic [191:0]     wd;
      logic [2:0]       exp_ready;
      logic             exp_we;
      logic             chk_data;
      logic [4:0]       exp_rd;
      logic [63:0]      exp_wd;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(input logic r, input logic f, input logic [2:0] v,
                               input logic [14:0] rd, input logic [191:0] wd,
                               input logic [2:0] er, input logic ew, input logic cd,
                               input logic [4:0] erd, input logic [63:0] ewd);
      vec_t t;
      t.rst = r; t.freeze = f; t.valid = v; t.rd = rd; t.wd = wd;
      t.exp_ready = er; t.exp_we = ew; t.chk_data = cd; t.exp_rd = erd; t.exp_wd = ewd;
      return t;
   endfunction

   // Drive one row, check the combinational grant, then the registered write.
   task automatic apply_row(input vec_t v, input int n);
      rst       = v.rst;
      freeze    = v.freeze;
      req_valid = v.valid;
      req_rd    = v.rd;
      req_wd    = v.wd;
      #1;
      check($sformatf("row%0d ready", n), 64'(req_ready), 64'(v.exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("row%0d rf_we", n), 64'(rf_we), 64'(v.exp_we));
      check($sformatf("row%0d busy", n), 64'(busy), 64'(v.exp_we));
      if (v.chk_data) begin
         check($sformatf("row%0d rf_rd", n), 64'(rf_rd), 64'(v.exp_rd));
         check($sformatf("row%0d rf_wd", n), rf_wd, v.exp_wd);
      end
   endtask

   // Reference round-robin pick: -1 when nothing is valid.
   function automatic int rr_pick(input logic [2:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (p + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // Random stream: model decides grant and expected write, queue holds it.
   task automatic run_stream(input int cycles, inout int model_ptr);
      logic [2:0]  v;
      logic [4:0]  rds[3];
      logic [63:0] wds[3];
      logic [SB_W-1:0] e;
      int g;
      for (int c = 0; c < cycles; c++) begin
         v = 3'($urandom_range(0, 7));
         for (int k = 0; k < NREQ; k++) begin
            rds[k] = 5'($urandom_range(0, 31));
            wds[k] = {$urandom, $urandom};
         end
         rst       = 1'b0;
         freeze    = 1'b0;
         req_valid = v;
         req_rd    = {rds[2], rds[1], rds[0]};
         req_wd    = {wds[2], wds[1], wds[0]};
         g = rr_pick(v, model_ptr);
         #1;
         check($sformatf("stream%0d ready", c), 64'(req_ready),
               (g >= 0) ? (64'd1 << g) : 64'd0);
         if (g >= 0) begin
            exp_q.push_back({(rds[g] != 5'd0), rds[g], wds[g]});
            model_ptr = (g + 1) % NREQ;
         end else begin
            exp_q.push_back({1'b0, 5'd0, 64'd0});
         end
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("stream%0d rf_we", c), 64'(rf_we), 64'(e[SB_W-1]));
         if (e[SB_W-1]) begin
            check($sformatf("stream%0d rf_rd", c), 64'(rf_rd), 64'(e[XLEN +: 5]));
            check($sformatf("stream%0d rf_wd", c), rf_wd, e[XLEN-1:0]);
         end
      end
   endtask

   initial begin
      int mptr;
      logic [14:0]  rall;
      logic [191:0] wall;
      rall = {5'd3, 5'd2, 5'd1};
      wall = {D2, D1, D0};

      // rst, frz, valid, rd, wd, ready, we, chk, rd, wd
      tbl[0]  = mk(1, 0, 3'b111, rall, wall, 3'b000, 0, 1, 5'd0, 64'd0);
      tbl[1]  = mk(0, 0, 3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 64'd0, D0}, 3'b001, 1, 1, 5'd5, D0);
      tbl[2]  = mk(0, 0, 3'b000, rall, wall, 3'b000, 0, 1, 5'd5, D0);
      tbl[3]  = mk(0, 0, 3'b100, {5'd9, 5'd0, 5'd0}, wall, 3'b100, 1, 1, 5'd9, D2);
      tbl[4]  = mk(0, 0, 3'b111, rall, wall, 3'b001, 1, 1, 5'd1, D0);
      tbl[5]  = mk(0, 0, 3'b111, rall, wall, 3'b010, 1, 1, 5'd2, D1);
      tbl[6]  = mk(0, 0, 3'b111, rall, wall, 3'b100, 1, 1, 5'd3, D2);
      tbl[7]  = mk(0, 0, 3'b111, rall, wall, 3'b001, 1, 1, 5'd1, D0);
      tbl[8]  = mk(0, 0, 3'b111, rall, wall, 3'b010, 1, 1, 5'd2, D1);
      tbl[9]  = mk(0, 0, 3'b111, rall, wall, 3'b100, 1, 1, 5'd3, D2);
      tbl[10] = mk(0, 0, 3'b001, {5'd3, 5'd2, 5'd0}, {D2, D1, DF}, 3'b001, 0, 0, 5'd0, 64'd0);
      tbl[11] = mk(0, 0, 3'b111, rall, wall, 3'b010, 1, 1, 5'd2, D1);
      tbl[12] = mk(0, 1, 3'b111, rall, wall, 3'b000, 0, 1, 5'd2, D1);
      tbl[13] = mk(0, 1, 3'b111, rall, wall, 3'b000, 0, 1, 5'd2, D1);
      tbl[14] = mk(0, 1, 3'b111, rall, wall, 3'b000, 0, 1, 5'd2, D1);
      tbl[15] = mk(0, 0, 3'b111, rall, wall, 3'b100, 1, 1, 5'd3, D2);
      tbl[16] = mk(0, 0, 3'b010, {5'd0, 5'd4, 5'd0}, wall, 3'b010, 1, 1, 5'd4, D1);
      tbl[17] = mk(1, 0, 3'b010, {5'd0, 5'd4, 5'd0}, wall, 3'b000, 0, 1, 5'd0, 64'd0);
      tbl[18] = mk(0, 0, 3'b010, {5'd0, 5'd4, 5'd0}, wall, 3'b010, 1, 1, 5'd4, D1);
      tbl[19] = mk(0, 0, 3'b111, rall, wall, 3'b100, 1, 1, 5'd3, D2);

      for (int i = 0; i < 20; i++) begin
         apply_row(tbl[i], i);
      end

      // After the table the pointer has wrapped back to requester 0.
      mptr = 0;
      run_stream(24, mptr);

`ifdef WB_FWD_EN
      // In-flight write to x7 bypasses onto matching operands only.
      req_valid = 3'b001;
      req_rd    = {5'd0, 5'd0, 5'd7};
      req_wd    = {64'd0, 64'd0, 64'h1234};
      @(posedge clk);
      #1;
      req_valid = 3'b000;
      fwd_rs1   = 5'd7;
      fwd_rs2   = 5'd0;
      rf_rd1    = 64'hAAAA_AAAA;
      rf_rd2    = 64'hBBBB_BBBB;
      #1;
      check("fwd op_rd1 hit", op_rd1, 64'h1234);
      check("fwd op_rd2 x0", op_rd2, 64'hBBBB_BBBB);
      fwd_rs2 = 5'd7;
      #1;
      check("fwd op_rd2 hit", op_rd2, 64'h1234);
      @(posedge clk);
      #1;
      check("fwd op_rd1 retired", op_rd1, 64'hAAAA_AAAA);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
